// File: rtl/inv_mix_columns_iter_if.sv
// rtl/inv_mix_columns_iter_if.sv - input/output handshake bundle for inv_mix_columns_iter
interface inv_mix_columns_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    modport master (
        output in_valid,
        output state_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_out
    );

    modport slave (
        input  in_valid,
        input  state_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_out
    );
endinterface

// File: rtl/inv_mix_columns_iter.sv
// rtl/inv_mix_columns_iter.sv - iterative AES InvMixColumns, COLS_PER_CYCLE columns per clock; INV_MIX_FWD_EN adds forward mode
module inv_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef INV_MIX_FWD_EN
    input  logic                    inv,
`endif
    inv_mix_columns_iter_if.slave   bus
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // col_cnt is 2 bits wide, so a step of 4 truncates to 0 and the counter
    // naturally sits at 0 for the single-group case.
    localparam logic [1:0] COL_STEP   = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_GROUP = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   buf_q, buf_d;
    logic [1:0]     col_cnt_q, col_cnt_d;
    logic [1:0]     col_idx;
    logic [31:0]    col_old;
    logic [31:0]    col_new;
`ifdef INV_MIX_FWD_EN
    logic           mode_q, mode_d;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse column transform; each byte multiple is built from x2/x4/x8.
    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        a[0] = col[31:24];
        a[1] = col[23:16];
        a[2] = col[15:8];
        a[3] = col[7:0];
        for (int k = 0; k < 4; k++) begin
            x2[k] = xtime(a[k]);
            x4[k] = xtime(x2[k]);
            x8[k] = xtime(x4[k]);
            m9[k] = x8[k] ^ a[k];
            mb[k] = x8[k] ^ x2[k] ^ a[k];
            md[k] = x8[k] ^ x4[k] ^ a[k];
            me[k] = x8[k] ^ x4[k] ^ x2[k];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

`ifdef INV_MIX_FWD_EN
    // Forward column transform (02 03 01 01 circulant).
    function automatic logic [31:0] fwd_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m2 [4];
        logic [7:0] m3 [4];
        a[0] = col[31:24];
        a[1] = col[23:16];
        a[2] = col[15:8];
        a[3] = col[7:0];
        for (int k = 0; k < 4; k++) begin
            m2[k] = xtime(a[k]);
            m3[k] = m2[k] ^ a[k];
        end
        return {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
                a[0]  ^ m2[1] ^ m3[2] ^ a[3],
                a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
                m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
    endfunction
`endif

    // Next-state logic: capture in IDLE, rewrite one column group per clock in BUSY, hold in DONE.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        col_cnt_d = col_cnt_q;
        col_idx   = 2'd0;
        col_old   = 32'd0;
        col_new   = 32'd0;
`ifdef INV_MIX_FWD_EN
        mode_d    = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    buf_d     = bus.state_in;
                    col_cnt_d = 2'd0;
`ifdef INV_MIX_FWD_EN
                    mode_d    = inv;
`endif
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    col_idx = col_cnt_q + 2'(g);
                    col_old = buf_q[{col_idx, 5'b0} +: 32];
`ifdef INV_MIX_FWD_EN
                    col_new = mode_q ? inv_col(col_old) : fwd_col(col_old);
`else
                    col_new = inv_col(col_old);
`endif
                    buf_d[{col_idx, 5'b0} +: 32] = col_new;
                end
                col_cnt_d = col_cnt_q + COL_STEP;
                if (col_cnt_q == LAST_GROUP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, buffer and counter registers; reset discards any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            buf_q     <= 128'd0;
            col_cnt_q <= 2'd0;
`ifdef INV_MIX_FWD_EN
            mode_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            col_cnt_q <= col_cnt_d;
`ifdef INV_MIX_FWD_EN
            mode_q    <= mode_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.state_out = buf_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb/tb_inv_mix_columns_iter.sv - self-checking bench for inv_mix_columns_iter against a GF(2^8) matrix model
module tb_inv_mix_columns_iter;
    parameter int CPC = 1;
    localparam int LAT = 4 / CPC;
    localparam int GAP = LAT + 2;

    localparam logic [127:0] V_MIXED  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_PLAIN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2_MIXED = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_01010101;
    localparam logic [127:0] V2_PLAIN = 128'hd4d4d4d5_2d26314c_db135345_01010101;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef INV_MIX_FWD_EN
    logic inv_r = 1'b1;
`endif
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    inv_mix_columns_iter_if bus ();

    inv_mix_columns_iter #(.COLS_PER_CYCLE(CPC)) dut (
        .clk (clk),
        .rst (rst),
`ifdef INV_MIX_FWD_EN
        .inv (inv_r),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'd0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'd0, a} << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inverse);
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   b;
        logic [127:0] r;
        if (inverse) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        r = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[32*c + 31 - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                b = 8'd0;
                for (int k = 0; k < 4; k++) b = b ^ gmul(coef[(k - row + 4) % 4], a[k]);
                r[32*c + 31 - 8*row -: 8] = b;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block, wait for acceptance, then count clocks until out_valid.
    task automatic send_block(input logic [127:0] d, output int lat, output logic [127:0] res);
        int guard;
`ifdef INV_MIX_FWD_EN
        logic saved;
`endif
        bus.state_in = d;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%0b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.state_in = rand128();
`ifdef INV_MIX_FWD_EN
        saved = inv_r;
        inv_r = ~inv_r;
`endif
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
`ifdef INV_MIX_FWD_EN
        inv_r = saved;
`endif
        res = bus.state_out;
    endtask

    task automatic release_block();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        logic [127:0] res;
        logic seen;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.state_out !== 128'd0) begin
            errors++;
            $display("FAIL reset_state in_ready=%0b out_valid=%0b state_out=%h required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.state_out);
        end
        bus.state_in = V_MIXED;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.state_out !== 128'd0) begin
            errors++;
            $display("FAIL reset_mid_busy in_ready=%0b out_valid=%0b state_out=%h required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.state_out);
        end
        seen = 1'b0;
        for (int i = 0; i < GAP; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard out_valid_seen=%0b required 0", seen);
        end
        send_block(V_MIXED, lat, res);
        checks++;
        if (res !== V_PLAIN || lat != LAT) begin
            errors++;
            $display("FAIL reset_then_accept state_out=%h lat=%0d required %h lat=%0d", res, lat, V_PLAIN, LAT);
        end
        release_block();
    endtask

    task automatic test_fips();
        int lat;
        logic [127:0] res;
        send_block(V_MIXED, lat, res);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL fips_latency got=%0d required=%0d", lat, LAT);
        end
        checks++;
        if (res !== V_PLAIN) begin
            errors++;
            $display("FAIL fips_result state_out=%h required %h", res, V_PLAIN);
        end
        checks++;
        if (res !== model(V_MIXED, 1'b1)) begin
            errors++;
            $display("FAIL fips_model state_out=%h required %h", res, model(V_MIXED, 1'b1));
        end
        release_block();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] res;
        send_block(V2_MIXED, lat, res);
        checks++;
        if (res !== V2_PLAIN) begin
            errors++;
            $display("FAIL bp_result state_out=%h required %h", res, V2_PLAIN);
        end
        bus.out_ready = 1'b0;
        bus.state_in  = V_MIXED;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.state_out !== V2_PLAIN) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d out_valid=%0b in_ready=%0b state_out=%h required 1 0 %h",
                         i, bus.out_valid, bus.in_ready, bus.state_out, V2_PLAIN);
            end
        end
        bus.in_valid = 1'b0;
        release_block();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release in_ready=%0b out_valid=%0b required 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        int guard;
        int lat;
        logic [127:0] r1;
        logic [127:0] r2;
        logic got1;
        bus.out_ready = 1'b1;
        bus.state_in  = V2_MIXED;
        bus.in_valid  = 1'b1;
        tick();
        t0 = cyc;
        bus.state_in = V_MIXED;
        got1 = 1'b0;
        r1 = 128'd0;
        t1 = t0;
        guard = 0;
        while (guard < 40) begin
            if (bus.in_ready) begin
                tick();
                t1 = cyc;
                break;
            end
            if (bus.out_valid) begin
                r1 = bus.state_out;
                got1 = 1'b1;
            end
            tick();
            guard++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got1 !== 1'b1 || r1 !== V2_PLAIN) begin
            errors++;
            $display("FAIL b2b_first seen=%0b state_out=%h required 1 %h", got1, r1, V2_PLAIN);
        end
        checks++;
        if (t1 - t0 != GAP) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d required=%0d", t1 - t0, GAP);
        end
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        r2 = bus.state_out;
        checks++;
        if (r2 !== V_PLAIN || lat != LAT) begin
            errors++;
            $display("FAIL b2b_second state_out=%h lat=%0d required %h lat=%0d", r2, lat, V_PLAIN, LAT);
        end
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        int lat;
        int hold;
        logic [127:0] d;
        logic [127:0] res;
        for (int n = 0; n < 10; n++) begin
            d = rand128();
            send_block(d, lat, res);
            checks++;
            if (res !== model(d, 1'b1) || lat != LAT) begin
                errors++;
                $display("FAIL random_%0d state_out=%h lat=%0d required %h lat=%0d",
                         n, res, lat, model(d, 1'b1), LAT);
            end
            hold = $urandom_range(0, 3);
            for (int i = 0; i < hold; i++) tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.state_out !== res) begin
                errors++;
                $display("FAIL random_hold_%0d out_valid=%0b state_out=%h required 1 %h",
                         n, bus.out_valid, bus.state_out, res);
            end
            release_block();
        end
    endtask

`ifdef INV_MIX_FWD_EN
    task automatic test_fwd();
        int lat;
        logic [127:0] d;
        logic [127:0] r1;
        logic [127:0] r2;
        inv_r = 1'b0;
        send_block(V_PLAIN, lat, r1);
        checks++;
        if (r1 !== V_MIXED || lat != LAT) begin
            errors++;
            $display("FAIL fwd_vector state_out=%h lat=%0d required %h lat=%0d", r1, lat, V_MIXED, LAT);
        end
        release_block();
        for (int n = 0; n < 6; n++) begin
            d = rand128();
            inv_r = 1'b0;
            send_block(d, lat, r1);
            release_block();
            checks++;
            if (r1 !== model(d, 1'b0)) begin
                errors++;
                $display("FAIL fwd_random_%0d state_out=%h required %h", n, r1, model(d, 1'b0));
            end
            inv_r = 1'b1;
            send_block(r1, lat, r2);
            release_block();
            checks++;
            if (r2 !== d) begin
                errors++;
                $display("FAIL round_trip_%0d state_out=%h required %h", n, r2, d);
            end
        end
        inv_r = 1'b1;
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.state_in  = 128'd0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_fips();
        test_backpressure();
        test_back_to_back();
        test_random();
`ifdef INV_MIX_FWD_EN
        test_fwd();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
